// File: rtl/lsu_pkg.sv
// Shared types and lane helpers for the load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_RDWAIT = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_e;

    // The spare size code 2'b11 behaves exactly like a word access.
    function automatic size_e norm_size(input logic [1:0] sz);
        return (sz == 2'b11) ? SZ_WORD : size_e'(sz);
    endfunction

    function automatic logic misaligned(input size_e sz, input logic [1:0] off);
        case (sz)
            SZ_HALF: return off[0];
            SZ_WORD: return |off;
            default: return 1'b0;
        endcase
    endfunction

    // Byte lane an access starts on, forced down to its natural alignment.
    function automatic logic [1:0] lane_sel(input size_e sz, input logic [1:0] off);
        case (sz)
            SZ_HALF: return {off[1], 1'b0};
            SZ_WORD: return 2'b00;
            default: return off;
        endcase
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Memory-side request/response bus of the load/store unit.
interface lsu_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic                req;
    logic                we;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W/8-1:0] be;
    logic [DATA_W-1:0]   wdata;
    logic                gnt;
    logic                rvalid;
    logic [DATA_W-1:0]   rdata;

    modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: store replication/byte enables and load extract/extend.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32
)(
    input  size_e               st_size,
    input  logic [1:0]          st_off,
    input  logic [DATA_W-1:0]   st_data,
    output logic [DATA_W/8-1:0] st_be,
    output logic [DATA_W-1:0]   st_lanes,
    input  size_e               ld_size,
    input  logic [1:0]          ld_off,
    input  logic                ld_unsigned,
    input  logic [DATA_W-1:0]   ld_data,
    output logic [DATA_W-1:0]   ld_result
);
    localparam int NB = DATA_W / 8;

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, otherwise
        // an uncovered case path silently infers a latch.
        st_be    = '1;
        st_lanes = st_data;
        case (st_size)
            SZ_BYTE: begin
                st_be    = NB'(1) << st_off;
                st_lanes = {NB{st_data[7:0]}};
            end
            SZ_HALF: begin
                st_be    = NB'(3) << st_off;
                st_lanes = {(NB/2){st_data[15:0]}};
            end
            default: ;
        endcase
    end

    assign ld_byte = ld_data[8*ld_off +: 8];
    assign ld_half = ld_data[16*ld_off[1] +: 16];

    always_comb begin
        ld_result = ld_data;
        case (ld_size)
            SZ_BYTE: ld_result = {{(DATA_W-8){~ld_unsigned & ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_result = {{(DATA_W-16){~ld_unsigned & ld_half[15]}}, ld_half};
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit control: runs one memory access at a time and stalls the pipeline meanwhile.
// Build option LSU_MISALIGN_TRAP_EN: trap misaligned half/word accesses instead of aligning them down.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TMO_CYC = 16
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              op_valid_i,
    input  logic              mem_rd_i,
    input  logic              mem_wr_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [4:0]        rd_i,
    input  logic              reg_we_i,
    output logic              stall_o,
    output logic              wb_valid_o,
    output logic              wb_we_o,
    output logic [4:0]        wb_rd_o,
    output logic [DATA_W-1:0] wb_data_o,
    output logic              err_o,
    lsu_if.master             mem
);
    localparam int CNT_W = $clog2(TMO_CYC + 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic                we_q, uns_q, reg_we_q;
    size_e               size_q;
    logic [1:0]          off_q;
    logic [4:0]          rd_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W/8-1:0] be_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                wb_valid_q, wb_we_q, err_q;
    logic [4:0]          wb_rd_q;
    logic [DATA_W-1:0]   wb_data_q;

    size_e               size_in;
    logic [1:0]          off_in;
    logic                is_mem, accept, trap, timeout;
    logic [DATA_W/8-1:0] st_be;
    logic [DATA_W-1:0]   st_lanes, ld_result;

    assign size_in = norm_size(size_i);
    assign off_in  = lane_sel(size_in, addr_i[1:0]);
    assign is_mem  = mem_rd_i | mem_wr_i;
    assign accept  = (state_q == ST_IDLE) && op_valid_i && is_mem;
    assign timeout = (cnt_q == CNT_W'(TMO_CYC - 1));
`ifdef LSU_MISALIGN_TRAP_EN
    assign trap = misaligned(size_in, addr_i[1:0]);
`else
    assign trap = 1'b0;
`endif

    lsu_align #(.DATA_W(DATA_W)) u_align (
        .st_size     (size_in),
        .st_off      (off_in),
        .st_data     (wdata_i),
        .st_be       (st_be),
        .st_lanes    (st_lanes),
        .ld_size     (size_q),
        .ld_off      (off_q),
        .ld_unsigned (uns_q),
        .ld_data     (mem.rdata),
        .ld_result   (ld_result)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept && !trap) state_d = ST_REQ;
            ST_REQ:    if (mem.gnt) state_d = we_q ? ST_IDLE : ST_RDWAIT;
                       else if (timeout) state_d = ST_IDLE;
            ST_RDWAIT: if (mem.rvalid || timeout) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            we_q       <= 1'b0;
            uns_q      <= 1'b0;
            reg_we_q   <= 1'b0;
            size_q     <= SZ_BYTE;
            off_q      <= '0;
            rd_q       <= '0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            wb_valid_q <= 1'b0;
            wb_we_q    <= 1'b0;
            err_q      <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register
            // samples the pre-edge values regardless of statement order.
            wb_valid_q <= 1'b0;
            wb_we_q    <= 1'b0;
            err_q      <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (op_valid_i && !is_mem) begin
                        wb_valid_q <= 1'b1;
                        wb_we_q    <= reg_we_i;
                        wb_rd_q    <= rd_i;
                        wb_data_q  <= DATA_W'(addr_i);
                    end else if (accept && trap) begin
                        err_q <= 1'b1;
                    end else if (accept) begin
                        we_q     <= mem_wr_i;
                        addr_q   <= {addr_i[ADDR_W-1:2], 2'b00};
                        be_q     <= st_be;
                        wdata_q  <= st_lanes;
                        size_q   <= size_in;
                        off_q    <= off_in;
                        uns_q    <= unsigned_i;
                        rd_q     <= rd_i;
                        reg_we_q <= reg_we_i;
                    end
                end
                ST_REQ, ST_RDWAIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    // A response arriving on the timeout cycle still wins.
                    if (state_q == ST_REQ && mem.gnt) begin
                        if (we_q) begin
                            wb_valid_q <= 1'b1;
                            wb_rd_q    <= rd_q;
                        end
                    end else if (state_q == ST_RDWAIT && mem.rvalid) begin
                        wb_valid_q <= 1'b1;
                        wb_we_q    <= reg_we_q;
                        wb_rd_q    <= rd_q;
                        wb_data_q  <= ld_result;
                    end else if (timeout) begin
                        err_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign stall_o    = (state_q != ST_IDLE) || accept;
    assign wb_valid_o = wb_valid_q;
    assign wb_we_o    = wb_we_q;
    assign wb_rd_o    = wb_rd_q;
    assign wb_data_o  = wb_data_q;
    assign err_o      = err_q;
    assign mem.req    = (state_q == ST_REQ);
    assign mem.we     = we_q;
    assign mem.addr   = addr_q;
    assign mem.be     = be_q;
    assign mem.wdata  = wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed self-checking bench for lsu_ctrl; honours LSU_MISALIGN_TRAP_EN for the misaligned case.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        op_valid_i, mem_rd_i, mem_wr_i, unsigned_i, reg_we_i;
    logic [1:0]  size_i;
    logic [31:0] addr_i, wdata_i;
    logic [4:0]  rd_i;
    logic        stall_o, wb_valid_o, wb_we_o, err_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;

    int n_tests = 0;
    int n_fail  = 0;

    lsu_if #(.DATA_W(32), .ADDR_W(32)) mem ();

    lsu_ctrl #(.DATA_W(32), .ADDR_W(32), .TMO_CYC(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op_valid_i (op_valid_i),
        .mem_rd_i   (mem_rd_i),
        .mem_wr_i   (mem_wr_i),
        .size_i     (size_i),
        .unsigned_i (unsigned_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .rd_i       (rd_i),
        .reg_we_i   (reg_we_i),
        .stall_o    (stall_o),
        .wb_valid_o (wb_valid_o),
        .wb_we_o    (wb_we_o),
        .wb_rd_o    (wb_rd_o),
        .wb_data_o  (wb_data_o),
        .err_o      (err_o),
        .mem        (mem)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed no end of test, required end before 100000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_op();
        op_valid_i = 1'b0;
        mem_rd_i   = 1'b0;
        mem_wr_i   = 1'b0;
        size_i     = 2'b00;
        unsigned_i = 1'b0;
        addr_i     = '0;
        wdata_i    = '0;
        rd_i       = '0;
        reg_we_i   = 1'b0;
    endtask

    // Present one load/store for a single cycle and check it is accepted with a stall.
    task automatic issue(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd, input logic [4:0] r);
        op_valid_i = 1'b1;
        mem_rd_i   = rd;
        mem_wr_i   = wr;
        size_i     = sz;
        unsigned_i = uns;
        addr_i     = a;
        wdata_i    = wd;
        rd_i       = r;
        reg_we_i   = 1'b1;
        #1;
        check("accept_stall", {stall_o, mem.req}, 2'b10);
        tick();
        clear_op();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctrl"}, {stall_o, wb_valid_o, wb_we_o, err_o, mem.req, mem.we}, 0);
        check({tag, "_wb"}, {wb_rd_o, wb_data_o}, 0);
        check({tag, "_bus"}, {mem.addr, mem.wdata}, 0);
        check({tag, "_be"}, mem.be, 0);
    endtask

    initial begin
        logic held;
        rst_n      = 1'b0;
        mem.gnt    = 1'b0;
        mem.rvalid = 1'b0;
        mem.rdata  = '0;
        clear_op();
        #12;
        check_all_zero("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // ALU pass-through
        tick();
        op_valid_i = 1'b1;
        addr_i     = 32'h1234;
        rd_i       = 5'd5;
        reg_we_i   = 1'b1;
        #1;
        check("alu_stall", stall_o, 1'b0);
        tick();
        clear_op();
        check("alu_wb", {wb_valid_o, wb_we_o, wb_rd_o, err_o, stall_o}, {1'b1, 1'b1, 5'd5, 1'b0, 1'b0});
        check("alu_data", wb_data_o, 32'h1234);
        tick();
        check("alu_pulse", wb_valid_o, 1'b0);

        // LB 0x103, grant after 2 request cycles, rvalid one cycle later
        issue(1'b1, 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 5'd7);
        check("lb_req", {mem.req, mem.we, stall_o}, 3'b101);
        check("lb_addr", mem.addr, 32'h100);
        check("lb_be", mem.be, 4'b1000);
        tick();
        check("lb_req_hold", mem.req, 1'b1);
        mem.gnt = 1'b1;
        tick();
        mem.gnt = 1'b0;
        check("lb_rdwait", {mem.req, stall_o, wb_valid_o}, 3'b010);
        mem.rvalid = 1'b1;
        mem.rdata  = 32'h80AABBCC;
        tick();
        mem.rvalid = 1'b0;
        check("lb_wb", {wb_valid_o, wb_we_o, wb_rd_o, stall_o}, {1'b1, 1'b1, 5'd7, 1'b0});
        check("lb_data", wb_data_o, 32'hFFFFFF80);

        // LBU 0x103; an rvalid during REQ must be ignored
        issue(1'b1, 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 5'd8);
        mem.gnt    = 1'b1;
        mem.rvalid = 1'b1;
        mem.rdata  = 32'hDEADBEEF;
        tick();
        mem.gnt    = 1'b0;
        mem.rvalid = 1'b0;
        check("lbu_early_rvalid", {wb_valid_o, stall_o, mem.req}, 3'b010);
        mem.rvalid = 1'b1;
        mem.rdata  = 32'h80AABBCC;
        tick();
        mem.rvalid = 1'b0;
        check("lbu_data", {wb_valid_o, wb_data_o}, {1'b1, 32'h00000080});

        // SH 0x202
        issue(1'b0, 1'b1, 2'b01, 1'b0, 32'h202, 32'h0000BEEF, 5'd0);
        check("sh_req", {mem.req, mem.we}, 2'b11);
        check("sh_addr", mem.addr, 32'h200);
        check("sh_be", mem.be, 4'b1100);
        check("sh_wdata", mem.wdata, 32'hBEEFBEEF);
        mem.gnt = 1'b1;
        tick();
        mem.gnt = 1'b0;
        check("sh_wb", {wb_valid_o, wb_we_o, stall_o, mem.req}, 4'b1000);

        // rd and wr both set -> store byte at 0x301
        issue(1'b1, 1'b1, 2'b00, 1'b0, 32'h301, 32'h12345678, 5'd3);
        check("sb_rdwr", {mem.we, mem.be}, {1'b1, 4'b0010});
        check("sb_wdata", mem.wdata, 32'h78787878);
        mem.gnt = 1'b1;
        tick();
        mem.gnt = 1'b0;
        check("sb_wb", {wb_valid_o, wb_we_o}, 2'b10);

        // LH signed at 0x402 picks the upper half
        issue(1'b1, 1'b0, 2'b01, 1'b0, 32'h402, 32'h0, 5'd9);
        check("lh_be", mem.be, 4'b1100);
        mem.gnt = 1'b1;
        tick();
        mem.gnt    = 1'b0;
        mem.rvalid = 1'b1;
        mem.rdata  = 32'h80017FFF;
        tick();
        mem.rvalid = 1'b0;
        check("lh_data", wb_data_o, 32'hFFFF8001);

        // size 11 behaves as word
        issue(1'b1, 1'b0, 2'b11, 1'b0, 32'h400, 32'h0, 5'd4);
        check("lw11_req", {mem.addr, mem.be}, {32'h400, 4'b1111});
        mem.gnt = 1'b1;
        tick();
        mem.gnt    = 1'b0;
        mem.rvalid = 1'b1;
        mem.rdata  = 32'h89ABCDEF;
        tick();
        mem.rvalid = 1'b0;
        check("lw11_data", {wb_valid_o, wb_data_o}, {1'b1, 32'h89ABCDEF});

        // LW with no grant: 16 request cycles then a timeout error
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h500, 32'h0, 5'd10);
        held = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (mem.req !== 1'b1 || err_o !== 1'b0) held = 1'b0;
            tick();
        end
        check("tmo_req_held", held, 1'b1);
        check("tmo_err", {err_o, mem.req, stall_o, wb_valid_o}, 4'b1000);
        mem.gnt = 1'b1;
        tick();
        mem.gnt = 1'b0;
        check("tmo_pulse_late_gnt", {err_o, mem.req, wb_valid_o, stall_o}, 4'b0000);

        // LW at misaligned 0x101
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 5'd11);
`ifdef LSU_MISALIGN_TRAP_EN
        check("mis_trap", {err_o, mem.req, stall_o, wb_valid_o}, 4'b1000);
        tick();
        check("mis_pulse", {err_o, mem.req}, 2'b00);
`else
        check("mis_align", {mem.req, mem.addr, mem.be}, {1'b1, 32'h100, 4'b1111});
        mem.gnt = 1'b1;
        tick();
        mem.gnt    = 1'b0;
        mem.rvalid = 1'b1;
        mem.rdata  = 32'hCAFEF00D;
        tick();
        mem.rvalid = 1'b0;
        check("mis_data", {wb_valid_o, err_o, wb_data_o}, {2'b10, 32'hCAFEF00D});
`endif

        // Reset while waiting for read data; a late rvalid must be ignored
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h600, 32'h0, 5'd12);
        mem.gnt = 1'b1;
        tick();
        mem.gnt = 1'b0;
        check("rd_pre_rst", {mem.req, stall_o, mem.addr}, {2'b01, 32'h600});
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_rst");
        tick();
        rst_n = 1'b1;
        mem.rvalid = 1'b1;
        mem.rdata  = 32'h12345678;
        tick();
        mem.rvalid = 1'b0;
        check("post_rst_rvalid", {wb_valid_o, stall_o, mem.req, err_o}, 4'b0000);
        check("post_rst_data", wb_data_o, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 The block SHALL use parameters: DATA_W (32; data width, multiple of 8), ADDR_W (32; byte address width), TMO_CYC (16; max cycles waiting on memory).
REQ-002 The block SHALL have these ports, one clock and asynchronous active-low reset first: clk in 1 (rising-edge clock); rst_n in 1 (async active-low reset).
REQ-003 Pipeline side: op_valid_i in 1 (op present); mem_rd_i in 1 (load); mem_wr_i in 1 (store); size_i in 2 (00 byte, 01 half, 10 word); unsigned_i in 1 (zero-extend load); addr_i in ADDR_W (ALU result/address); wdata_i in DATA_W (rs2 value); rd_i in 5 (dest reg); reg_we_i in 1 (writeback enable).
REQ-004 Pipeline outputs: stall_o out 1 (hold upstream); wb_valid_o out 1 (result pulse); wb_we_o out 1; wb_rd_o out 5; wb_data_o out DATA_W; err_o out 1 (misalign/timeout pulse).
REQ-005 Memory side: mem_req_o out 1; mem_we_o out 1; mem_addr_o out ADDR_W (word-aligned); mem_be_o out DATA_W/8 (byte enables); mem_wdata_o out DATA_W (lane-shifted); mem_gnt_i in 1 (request accepted); mem_rvalid_i in 1; mem_rdata_i in DATA_W.

Function
REQ-006 FSM states SHALL be IDLE, REQ, RDWAIT; encodings from the shared package.
REQ-007 In IDLE with op_valid_i=1 and neither mem_rd_i nor mem_wr_i, next cycle SHALL give wb_valid_o=1, wb_data_o=addr_i, wb_rd_o=rd_i, wb_we_o=reg_we_i; stall_o=0; latency 1.
REQ-008 In IDLE with a load or store accepted, request fields SHALL be registered, stall_o asserted combinationally that cycle, state -> REQ.
REQ-009 In REQ, mem_req_o=1 with stable mem_we_o/addr/be/wdata until mem_gnt_i=1; store -> IDLE with wb_valid_o=1, wb_we_o=0; load -> RDWAIT.
REQ-010 In RDWAIT, on mem_rvalid_i=1 the selected lane SHALL be shifted to bit 0, sign- or zero-extended per unsigned_i, registered to wb_data_o with wb_valid_o=1, state -> IDLE.
REQ-011 stall_o SHALL be 1 from acceptance until the cycle wb_valid_o or err_o pulses, then 0.
REQ-012 mem_be_o SHALL be 0001<<addr[1:0] (byte), 0011<<addr[1:0] (half), 1111 (word); mem_wdata_o SHALL replicate the low byte/half across lanes.
REQ-013 mem_rvalid_i outside RDWAIT and mem_gnt_i outside REQ SHALL be ignored.
REQ-014 A wait counter SHALL count cycles in REQ+RDWAIT; reaching TMO_CYC SHALL pulse err_o, drop mem_req_o, return to IDLE, no writeback.
REQ-015 mem_rd_i and mem_wr_i both 1 SHALL be treated as a store.
REQ-016 size_i=11 SHALL be treated as word.
REQ-017 wb_valid_o and err_o SHALL be single-cycle pulses, never both high.

Reset
REQ-018 rst_n low SHALL asynchronously force state IDLE, counter 0, and every output 0.
REQ-019 Reset mid-transaction SHALL abandon it; a later mem_rvalid_i/mem_gnt_i SHALL be ignored.

Configuration
REQ-020 With LSU_MISALIGN_TRAP_EN defined, half at odd address or word with addr[1:0]!=0 SHALL issue no request, pulse err_o next cycle, stall_o for that one cycle only.
REQ-021 Without LSU_MISALIGN_TRAP_EN, misaligned addresses SHALL be forced down to natural alignment and proceed normally; err_o only from timeout.

Structure
REQ-022 A shared package lsu_pkg SHALL hold the FSM state type, size encodings, and the load/store lane-select function.
REQ-023 One sub-module lsu_align SHALL implement the combinational store lane shift/byte enables and load extract/extend.

Verification
REQ-024 ALU op: addr_i=0x1234, rd_i=5, reg_we_i=1 -> next cycle wb_valid_o=1, wb_data_o=0x1234, wb_rd_o=5, stall_o never 1.
REQ-025 LB addr 0x103, rdata 0x80AABBCC, gnt after 2 cycles, rvalid 1 later -> mem_be_o=1000, wb_data_o=0xFFFFFF80; LBU -> 0x00000080.
REQ-026 SH addr 0x202, wdata 0x0000BEEF -> mem_addr_o=0x200, mem_be_o=1100, mem_wdata_o=0xBEEFBEEF, wb_valid_o=1 with wb_we_o=0 after gnt.
REQ-027 LW with gnt never asserted, TMO_CYC=16 -> err_o pulse after 16 wait cycles, mem_req_o drops, stall_o releases.
REQ-028 LW addr 0x101: with macro -> no mem_req_o, err_o=1; without -> mem_addr_o=0x100, normal load.
REQ-029 rst_n low in RDWAIT, then rvalid after release -> all outputs 0, no wb_valid_o.
